// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: shares one memory port between fetch and data,
// decodes the IR opcode state by state, traps on illegal opcodes or memory timeout.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 load_half,
    output logic                 load_half_unsigned,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [7:0]           WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic [7:0]           r_wait_cnt;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 w_mem_state;
    logic                 w_timeout;
    logic                 w_retire;
    logic                 w_half;
    logic                 w_half_u;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    // Ready on the last allowed cycle still completes the access.
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_half      = (opcode == 6'h21) || (opcode == 6'h25);
    assign w_half_u    = (opcode == 6'h25);
    assign instr_retired = r_retired;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:                      w_next = S_EXEC;
                    6'h23, 6'h2B, 6'h21, 6'h25: w_next = S_MEMADR;
                    6'h04:                      w_next = S_BRANCH;
                    6'h08:                      w_next = S_ADDIEX;
                    6'h02:                      w_next = S_JUMP;
                    default:                    w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default:  w_next = S_TRAP;
        endcase
        if (w_timeout) w_next = S_TRAP;
    end

    always_comb begin
        pc_write           = 1'b0;
        pc_write_cond      = 1'b0;
        pc_source          = 2'd0;
        i_or_d             = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        ir_write           = 1'b0;
        reg_dst            = 1'b0;
        reg_write          = 1'b0;
        mem_to_reg         = 1'b0;
        alu_src_a          = 1'b0;
        alu_src_b          = 2'd0;
        alu_op             = 2'd0;
        load_half          = 1'b0;
        load_half_unsigned = 1'b0;
        trap               = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd3;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                i_or_d             = 1'b1;
                mem_read           = 1'b1;
                load_half          = w_half;
                load_half_unsigned = w_half_u;
            end
            S_MEMWB: begin
                mem_to_reg         = 1'b1;
                reg_write          = 1'b1;
                load_half          = w_half;
                load_half_unsigned = w_half_u;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_source     = 2'd1;
                pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_retired  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_mem_state && !mem_ready)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_retire)
                r_retired <= r_retired + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table vectors, random instruction stream
// against an instruction-level model, and hand-written corner sequences.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       load_half;
        logic       load_half_unsigned;
        logic       trap;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        int         zpos;
        int         zn;
        int         len;
        int         probe_pos;
        int         probe_ph;
    } vec_t;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3;
    localparam int PH_MEMRD = 4, PH_MEMWB = 5, PH_MEMWR = 6, PH_EXEC = 7;
    localparam int PH_RWB = 8, PH_BRANCH = 9, PH_ADDIEX = 10, PH_ADDIWB = 11;
    localparam int PH_JUMP = 12, PH_TRAP = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic        load_half, load_half_unsigned, trap;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [31:0] instr_retired;
    ctrl_t       act;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .load_half(load_half), .load_half_unsigned(load_half_unsigned),
        .trap(trap), .instr_retired(instr_retired)
    );

    assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                  mem_write, ir_write, reg_dst, reg_write, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, load_half,
                  load_half_unsigned, trap};

    function automatic ctrl_t exp_of(input int ph, input logic [5:0] op,
                                     input logic rdy);
        ctrl_t c;
        logic  h;
        logic  hu;
        c  = '0;
        h  = (op == 6'h21) || (op == 6'h25);
        hu = (op == 6'h25);
        case (ph)
            PH_FETCH: begin
                c.mem_read = 1; c.alu_src_b = 2'd1;
                c.ir_write = rdy; c.pc_write = rdy;
            end
            PH_DECODE: c.alu_src_b = 2'd3;
            PH_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            PH_MEMRD: begin
                c.i_or_d = 1; c.mem_read = 1;
                c.load_half = h; c.load_half_unsigned = hu;
            end
            PH_MEMWB: begin
                c.mem_to_reg = 1; c.reg_write = 1;
                c.load_half = h; c.load_half_unsigned = hu;
            end
            PH_MEMWR: begin c.i_or_d = 1; c.mem_write = 1; end
            PH_EXEC: begin c.alu_src_a = 1; c.alu_op = 2'd2; end
            PH_RWB: begin c.reg_dst = 1; c.reg_write = 1; end
            PH_BRANCH: begin
                c.alu_src_a = 1; c.alu_op = 2'd1;
                c.pc_source = 2'd1; c.pc_write_cond = 1;
            end
            PH_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            PH_ADDIWB: c.reg_write = 1;
            PH_JUMP: begin c.pc_source = 2'd2; c.pc_write = 1; end
            PH_TRAP: c.trap = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk_ctrl(input string nm, input ctrl_t e);
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, e);
        end
    endtask

    task automatic chk_cnt(input string nm);
        n_chk++;
        if (instr_retired !== model_cnt) begin
            n_fail++;
            $display("FAIL %s: instr_retired got %0d expected %0d",
                     nm, instr_retired, model_cnt);
        end
    endtask

    // Apply one cycle at posedge+1, compare at posedge+2, advance.
    task automatic cyc(input int ph, input logic [5:0] op, input logic rdy);
        opcode = op;
        mem_ready = rdy;
        #1;
        chk_ctrl($sformatf("ctrl ph%0d op%02h", ph, op), exp_of(ph, op, rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        model_cnt = 0;
        rst_n = 1'b1;
        chk_cnt("reset cnt");
        cyc(PH_IDLE, 6'h00, 1'b1);
    endtask

    // Instruction-level model: fst/mst = stall cycles before ready.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
        logic rb;
        for (int i = 0; i < fst; i++) cyc(PH_FETCH, op, 1'b0);
        cyc(PH_FETCH, op, 1'b1);
        rb = 1'($urandom & 1);
        cyc(PH_DECODE, op, rb);
        case (op)
            6'h00: begin cyc(PH_EXEC, op, rb); cyc(PH_RWB, op, rb); end
            6'h23, 6'h21, 6'h25: begin
                cyc(PH_MEMADR, op, rb);
                for (int i = 0; i < mst; i++) cyc(PH_MEMRD, op, 1'b0);
                cyc(PH_MEMRD, op, 1'b1);
                cyc(PH_MEMWB, op, rb);
            end
            6'h2B: begin
                cyc(PH_MEMADR, op, rb);
                for (int i = 0; i < mst; i++) cyc(PH_MEMWR, op, 1'b0);
                cyc(PH_MEMWR, op, 1'b1);
            end
            6'h04: cyc(PH_BRANCH, op, rb);
            6'h08: begin cyc(PH_ADDIEX, op, rb); cyc(PH_ADDIWB, op, rb); end
            6'h02: cyc(PH_JUMP, op, rb);
            default: begin
                for (int i = 0; i < 3; i++) cyc(PH_TRAP, op, rb);
                chk_cnt("trap holds cnt");
                return;
            end
        endcase
        model_cnt++;
        chk_cnt($sformatf("retire op%02h", op));
    endtask

    vec_t vecs[9];
    logic [5:0] legal[7];

    initial begin
        vecs[0] = '{6'h00, 0, 0, 4, 3, PH_RWB};
        vecs[1] = '{6'h23, 3, 3, 8, 7, PH_MEMWB};
        vecs[2] = '{6'h25, 0, 0, 5, 3, PH_MEMRD};
        vecs[3] = '{6'h21, 0, 0, 5, 4, PH_MEMWB};
        vecs[4] = '{6'h2B, 3, 2, 6, 4, PH_MEMWR};
        vecs[5] = '{6'h04, 0, 0, 3, 2, PH_BRANCH};
        vecs[6] = '{6'h02, 0, 0, 3, 2, PH_JUMP};
        vecs[7] = '{6'h08, 0, 0, 4, 3, PH_ADDIWB};
        vecs[8] = '{6'h00, 0, 2, 6, 5, PH_RWB};
        legal = '{6'h00, 6'h23, 6'h2B, 6'h21, 6'h25, 6'h04, 6'h08};

        @(posedge clk);
        #1;
        do_reset();

        foreach (vecs[k]) begin
            for (int p = 0; p < vecs[k].len; p++) begin
                opcode = vecs[k].op;
                mem_ready = (p >= vecs[k].zpos && p < vecs[k].zpos + vecs[k].zn)
                            ? 1'b0 : 1'b1;
                #1;
                if (p == vecs[k].probe_pos)
                    chk_ctrl($sformatf("vec%0d probe", k),
                             exp_of(vecs[k].probe_ph, vecs[k].op, mem_ready));
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b0;
            #1;
            chk_ctrl($sformatf("vec%0d back in fetch", k),
                     exp_of(PH_FETCH, vecs[k].op, 1'b0));
            model_cnt++;
            chk_cnt($sformatf("vec%0d retire", k));
        end

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = (n % 6 == 5) ? 6'h02 : legal[$urandom_range(6, 0)];
            run_instr(op, $urandom_range(14, 0), $urandom_range(14, 0));
        end

        run_instr(6'h23, 0, 14);
        run_instr(6'h2B, 14, 14);

        do_reset();
        for (int i = 0; i < 15; i++) cyc(PH_FETCH, 6'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(PH_TRAP, 6'h00, 1'($urandom & 1));
        chk_cnt("fetch timeout cnt");

        do_reset();
        run_instr(6'h00, 14, 0);

        run_instr(6'h3F, 0, 0);

        do_reset();
        run_instr(6'h00, 0, 0);
        cyc(PH_FETCH, 6'h2B, 1'b1);
        cyc(PH_DECODE, 6'h2B, 1'b0);
        cyc(PH_MEMADR, 6'h2B, 1'b0);
        cyc(PH_MEMWR, 6'h2B, 1'b0);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_cnt = 0;
        chk_ctrl("reset mid memwr", exp_of(PH_IDLE, 6'h2B, 1'b1));
        chk_cnt("reset mid memwr cnt");
        cyc(PH_IDLE, 6'h2B, 1'b1);
        run_instr(6'h08, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
